// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared encodings and CTRL layout for counter_unit
//   Contents: CTRL width, per-channel field offsets, channel mode encoding,
//   prescaler width and CTRL field index helpers.
package counter_pkg;

  localparam int CTRL_W     = 9;   // three 3-bit channel fields
  localparam int CH_FIELD_W = 3;   // {mode[1:0], en} per channel
  localparam int EN_OFS     = 0;   // en bit offset within a field
  localparam int MODE_OFS   = 1;   // mode LSB offset within a field
  localparam int NUM_CH     = 3;
  localparam int PRESC_W    = 16;  // holds PRESCALE-1 up to 65534

  localparam logic [1:0] CH_CTRL = 2'd3;  // counter_ch value addressing CTRL

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_SQUARE   = 2'b10,
    MODE_ONESHOT2 = 2'b11   // reserved code, behaves as one-shot
  } mode_e;

  function automatic int en_bit(input int ch);
    return CH_FIELD_W * ch + EN_OFS;
  endfunction

  function automatic int mode_lsb(input int ch);
    return CH_FIELD_W * ch + MODE_OFS;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// rtl/counter_channel.sv - one counter channel: load, count and output flag
//   clk      : system clock
//   rst      : synchronous active-high reset
//   tick_i   : shared prescaled count tick
//   we_i     : load strobe for this channel
//   wdata_i  : load value
//   en_i     : channel enable from CTRL
//   mode_i   : channel mode from CTRL
//   count_o  : current count register
//   flag_o   : registered output flag
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             flag_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    flag_d  = flag_q;
    if (we_i) begin
      // A load wins over a same-cycle tick; square wave starts high.
      load_d  = wdata_i;
      count_d = wdata_i;
      flag_d  = (mode_i == MODE_SQUARE);
    end else if (en_i) begin
      case (mode_i)
        MODE_PERIODIC: begin
          // Pulse lasts one clk, not one tick, so clear on every enabled cycle.
          flag_d = 1'b0;
          if (tick_i) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (load_q != '0) begin
              count_d = load_q;
              flag_d  = 1'b1;
            end else begin
              count_d = '0;
            end
          end
        end
        MODE_SQUARE: begin
          if (tick_i) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (load_q != '0) begin
              count_d = load_q;
              flag_d  = ~flag_q;
            end
          end
        end
        default: begin
          // One-shot: flag latches on the 1->0 transition until the next load.
          if (tick_i && (count_q != '0)) begin
            count_d = count_q - ONE;
            if (count_q == ONE) flag_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q  <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign count_o = count_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/counter_unit.sv
// rtl/counter_unit.sv - three-channel timer/counter with shared prescaler
//   clk                : system clock
//   rst                : synchronous active-high reset
//   counter_we         : bus write strobe
//   counter_val        : bus write data
//   counter_ch         : 0..2 channel load register, 3 control register
//   counter_out        : combinational read data (count or CTRL)
//   counter0/1/2_out   : registered channel output flags
module counter_unit
  import counter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter_we,
  input  logic [WIDTH-1:0] counter_val,
  input  logic [1:0]       counter_ch,
  output logic [WIDTH-1:0] counter_out,
  output logic             counter0_out,
  output logic             counter1_out,
  output logic             counter2_out
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               tick;
  logic [WIDTH-1:0]   count_w [NUM_CH];
  logic [NUM_CH-1:0]  flag_w;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  assign ctrl_d  = (counter_we && (counter_ch == CH_CTRL)) ?
                   counter_val[CTRL_W-1:0] : ctrl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      ctrl_q  <= '0;
    end else begin
      presc_q <= presc_d;
      ctrl_q  <= ctrl_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick),
      .we_i   (counter_we && (counter_ch == 2'(g))),
      .wdata_i(counter_val),
      .en_i   (ctrl_q[en_bit(g)]),
      .mode_i (mode_e'(ctrl_q[mode_lsb(g) +: 2])),
      .count_o(count_w[g]),
      .flag_o (flag_w[g])
    );
  end

  always_comb begin
    counter_out = '0;
    case (counter_ch)
      2'd0:    counter_out = count_w[0];
      2'd1:    counter_out = count_w[1];
      2'd2:    counter_out = count_w[2];
      default: counter_out = WIDTH'(ctrl_q);
    endcase
  end

  assign counter0_out = flag_w[0];
  assign counter1_out = flag_w[1];
  assign counter2_out = flag_w[2];

endmodule

// File: doc/counter_unit.md
COUNTER_UNIT -- requirements
Module: counter_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data and count width of each channel.
REQ-002 SHALL have parameter: PRESCALE, 1, clk cycles per count tick (legal range 1..65535).
REQ-003 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: counter_we  input  1  write strobe from bus decoder.
REQ-006 SHALL have port: counter_val  input  WIDTH  write data (bus Peripheral_in).
REQ-007 SHALL have port: counter_ch  input  2  target select: 0..2 channel load register, 3 control register.
REQ-008 SHALL have port: counter_out  output  WIDTH  read data (bus counter_out).
REQ-009 SHALL have ports: counter0_out, counter1_out, counter2_out  output  1 each  channel output flags.

Function
REQ-010 SHALL hold per channel i (0..2): load register L[i], count register C[i], output flag O[i].
REQ-011 SHALL hold control register CTRL, 9 bits; channel i field CTRL[3i+2:3i] = {mode[1:0], en}.
REQ-012 SHALL decode modes: 00 one-shot, 01 periodic pulse, 10 square wave, 11 treated as one-shot.
REQ-013 SHALL generate shared tick: prescale counter 0..PRESCALE-1; tick=1 in the cycle it equals PRESCALE-1, then wraps to 0; PRESCALE=1 gives tick every cycle.
REQ-014 SHALL, on counter_we with counter_ch=i<3: L[i]<=counter_val, C[i]<=counter_val, O[i]<=1 in square mode else 0, all visible next cycle.
REQ-015 SHALL, on counter_we with counter_ch=3: CTRL<=counter_val[8:0]; C, L, O unchanged.
REQ-016 SHALL, for channels with en=0, hold C[i] and O[i].
REQ-017 SHALL, one-shot, on tick with en=1: if C!=0 then C<=C-1; O<=1 when C goes 1->0; O remains 1 until next write to that channel; C==0 stays 0.
REQ-018 SHALL, periodic, on tick with en=1: if C>1 then C<=C-1, O<=0; if C<=1 and L!=0 then C<=L, O<=1 for exactly one clk cycle; L==0 holds C=0, O=0.
REQ-019 SHALL, square, on tick with en=1: if C>1 then C<=C-1; if C<=1 and L!=0 then C<=L, O<=~O (period 2*L ticks); L==0 holds C and O.
REQ-020 SHALL give a channel write priority over a same-cycle tick for that channel; other channels tick normally.
REQ-021 SHALL drive counter_out combinationally: C[counter_ch] for ch 0..2, {zeros, CTRL} for ch 3; zero latency.
REQ-022 SHALL use WIDTH-bit unsigned arithmetic; decrement never wraps below 0.
REQ-023 SHALL drive counterN_out directly from O[N] registers (no glitch).

Reset
REQ-024 SHALL, when rst=1 at a clk edge, clear L, C, O, CTRL and prescale counter to 0; counter_out then reads 0.
REQ-025 SHALL let rst override any simultaneous counter_we or tick, including mid-count.

Structure
REQ-026 SHALL place mode encodings, CTRL field offsets and CTRL width (9) in shared package counter_pkg.
REQ-027 SHALL implement one per-channel sub-module counter_channel (L, C, O, mode logic), instantiated three times; prescaler, CTRL and read mux at top.

Verification
REQ-028 SHALL cover: reset then ch3 write 0x001 (ch0 en, one-shot), ch0 write 5 -> C0 reads 5,4,3,2,1,0 on successive cycles; counter0_out=1 from C0=0 and stays 1.
REQ-029 SHALL cover: ch1 periodic, L=3, PRESCALE=1 -> counter1_out one-cycle pulse every 3 cycles, C1 sequence 3,2,1,3,2,1.
REQ-030 SHALL cover: ch2 square, L=4 -> counter2_out starts 1, toggles every 4 cycles (8-cycle period); L=0 -> output frozen.
REQ-031 SHALL cover: PRESCALE=4, one-shot load 2 -> C decrements once per 4 cycles, reaches 0 after 8 cycles.
REQ-032 SHALL cover: write to ch0 value 9 in same cycle as tick -> C0=9 next cycle; rst asserted mid-count -> all outputs 0 next cycle, ch3 read returns 0.
